layered_color_mapper: RTL and testbench
=======================================

LAYERED_COLOR_MAPPER -- requirements
Module: layered_color_mapper

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 4, number of prioritised overlay layers (2..16).
REQ-002 SHALL have parameter COLOR_W, default 8, bits per colour channel (8..10).
REQ-003 SHALL have parameter BLINK_FRAMES, default 30, frames per blink half-period (1..255).
REQ-004 SHALL have port Clk  input  1  the single clock for all logic.
REQ-005 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port frame_start  input  1  one-cycle pulse at the start of each frame.
REQ-007 SHALL have port pix_valid  input  1  DrawX, DrawY and is_layer qualify the current pixel.
REQ-008 SHALL have port DrawX  input  10  horizontal pixel coordinate.
REQ-009 SHALL have port DrawY  input  10  vertical pixel coordinate.
REQ-010 SHALL have port is_layer  input  NUM_LAYERS  hit vector; bit 0 has the highest priority.
REQ-011 SHALL have port blink_en  input  NUM_LAYERS  per-layer blink enable.
REQ-012 SHALL have port pal_we  input  1  palette write strobe.
REQ-013 SHALL have port pal_idx  input  4  palette entry to write.
REQ-014 SHALL have port pal_rgb  input  3*COLOR_W  write data, packed {R,G,B}.
REQ-015 SHALL have port VGA_R, VGA_G, VGA_B  output  COLOR_W each  registered pixel colour.
REQ-016 SHALL have port pix_valid_out  output  1  pix_valid delayed to align with VGA_*.

Function
REQ-017 SHALL hold a palette of NUM_LAYERS registers, each 3*COLOR_W bits wide.
REQ-018 SHALL write pal_rgb into entry pal_idx on a cycle where pal_we=1 and pal_idx<NUM_LAYERS; SHALL ignore the write when pal_idx>=NUM_LAYERS.
REQ-019 SHALL use the pre-write palette value for a pixel whose lookup occurs on the same cycle as a write to that entry; the new value SHALL apply from the next cycle.
REQ-020 SHALL count frame_start pulses in frame_cnt, 0..BLINK_FRAMES-1; at BLINK_FRAMES-1 a pulse SHALL wrap frame_cnt to 0 and toggle blink_phase.
REQ-021 SHALL compute the masked hit vector as eff = is_layer & ~(blink_en & {NUM_LAYERS{blink_phase}}).
REQ-022 SHALL select the winner as the lowest-index set bit of eff; when eff=0 the pixel SHALL be background.
REQ-023 SHALL compute the background at 8 bits as R=0x3F, G=0x00, B=0x7F-{1'b0,DrawX[9:3]} (mod 256), then left-align it to COLOR_W with zero-filled LSBs.
REQ-024 SHALL use a pipeline of exactly 2 cycles: stage 1 registers the winner index, the hit flag and the background value; stage 2 registers the palette or background colour into VGA_*.
REQ-025 SHALL produce pix_valid_out equal to pix_valid delayed 2 cycles; VGA_* SHALL update every cycle regardless of pix_valid.
REQ-026 SHALL apply a blink_phase toggle from the cycle after the frame_start pulse; a pixel already in stage 1 keeps its mask.
REQ-027 SHALL ignore DrawY for colour selection; DrawY is reserved for future row effects.

Reset
REQ-028 SHALL, while Reset=1, force VGA_R/G/B=0, pix_valid_out=0, frame_cnt=0, blink_phase=0 and clear both pipeline stages.
REQ-029 SHALL reset the palette to: entry 0 white, entry 1 white, entry 2 red (full R), entry 3 green (full G), entries 4+ black.
REQ-030 SHALL let Reset override any simultaneous pal_we or frame_start.
REQ-031 SHALL, when Reset is asserted mid-frame, drop in-flight pixels and set pix_valid_out=0 two cycles after Reset deasserts unless new pix_valid arrives.

Structure
REQ-032 SHALL place the rgb_t struct (r, g, b of COLOR_W bits) and the default palette constants in a shared package, vga_color_pkg.
REQ-033 SHALL implement the priority encoder (NUM_LAYERS-bit vector to index plus hit flag) as sub-module layer_prio_enc; all other logic stays in the top module.

Verification
REQ-034 SHALL cover: after reset, is_layer=4'b1100, pix_valid=1 -> 2 cycles later VGA=(FF,00,00) and pix_valid_out=1.
REQ-035 SHALL cover: is_layer=0, DrawX=80 -> VGA=(3F,00,75).
REQ-036 SHALL cover: pal_we=1, pal_idx=2, pal_rgb=0x0000FF on the same cycle as is_layer=4'b0100 -> first pixel red, next pixel blue; pal_idx=9 -> no entry changes.
REQ-037 SHALL cover: BLINK_FRAMES=2, blink_en=4'b0001, is_layer=4'b0011 held -> white (layer 0) for 2 frames, white (layer 1) on fall-through, then with entry 1 rewritten to 0x123456 the output alternates every 2 frame_start pulses.
REQ-038 SHALL cover: Reset asserted for 1 cycle during a streaming pixel burst -> next 2 cycles VGA=0 and pix_valid_out=0, blink_phase=0, palette restored to defaults.
REQ-039 SHALL cover: NUM_LAYERS=8, COLOR_W=10, is_layer=8'h80 -> VGA=0, and background B=0x1D4 at DrawX=80.

Source files
------------

// File: rtl/vga_color_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_color_pkg
// Description : Shared colour types and default palette assignments for the
//               layered colour mapper.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_color_pkg;

    localparam int MAX_COLOR_W = 10;

    typedef struct packed {
        logic [MAX_COLOR_W-1:0] r;
        logic [MAX_COLOR_W-1:0] g;
        logic [MAX_COLOR_W-1:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        PAL_BLACK = 2'd0,
        PAL_WHITE = 2'd1,
        PAL_RED   = 2'd2,
        PAL_GREEN = 2'd3
    } pal_color_e;

    function automatic pal_color_e default_color(input int idx);
        pal_color_e c;
        case (idx)
            0:       c = PAL_WHITE;
            1:       c = PAL_WHITE;
            2:       c = PAL_RED;
            3:       c = PAL_GREEN;
            default: c = PAL_BLACK;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/layer_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : layer_prio_enc
// Description : Priority encoder; lowest-index set bit wins, o_hit flags any.
// Revision    : 1.0 - initial release
// ============================================================================
module layer_prio_enc #(
    parameter int NUM_LAYERS = 4,
    parameter int IDX_W      = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic [NUM_LAYERS-1:0] i_vec,
    output logic [IDX_W-1:0]      o_idx,
    output logic                  o_hit
);

    // Scanning downward lets the lowest set bit be the last (winning) write.
    always_comb begin
        o_idx = '0;
        o_hit = 1'b0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = IDX_W'(i);
                o_hit = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/layered_color_mapper.sv
`default_nettype none
// ============================================================================
// Module      : layered_color_mapper
// Description : Two-stage pixel colour pipeline selecting between prioritised
//               palette layers (with blink masking) and a gradient background.
// Revision    : 1.0 - initial release
// ============================================================================
module layered_color_mapper
    import vga_color_pkg::*;
#(
    parameter int NUM_LAYERS   = 4,
    parameter int COLOR_W      = 8,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    frame_start,
    input  logic                    pix_valid,
    input  logic [9:0]              DrawX,
    input  logic [9:0]              DrawY,
    input  logic [NUM_LAYERS-1:0]   is_layer,
    input  logic [NUM_LAYERS-1:0]   blink_en,
    input  logic                    pal_we,
    input  logic [3:0]              pal_idx,
    input  logic [3*COLOR_W-1:0]    pal_rgb,
    output logic [COLOR_W-1:0]      VGA_R,
    output logic [COLOR_W-1:0]      VGA_G,
    output logic [COLOR_W-1:0]      VGA_B,
    output logic                    pix_valid_out
);

    localparam int         c_IDX_W    = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int         c_RGB_W    = 3 * COLOR_W;
    localparam logic [7:0] c_CNT_LAST = 8'(BLINK_FRAMES - 1);

    logic [c_RGB_W-1:0]    r_pal_q   [NUM_LAYERS];
    logic [c_RGB_W-1:0]    w_pal_d   [NUM_LAYERS];
    logic [c_RGB_W-1:0]    w_pal_rst [NUM_LAYERS];

    logic                  r_wr_pend_q, w_wr_pend_d;
    logic [3:0]            r_wr_idx_q,  w_wr_idx_d;
    logic [c_RGB_W-1:0]    r_wr_rgb_q,  w_wr_rgb_d;

    logic [7:0]            r_frame_cnt_q,   w_frame_cnt_d;
    logic                  r_blink_phase_q, w_blink_phase_d;

    logic [NUM_LAYERS-1:0] w_eff;
    logic [c_IDX_W-1:0]    w_win_idx;
    logic                  w_hit;
    logic [7:0]            w_bg_b8;
    logic [COLOR_W-1:0]    w_bg_r, w_bg_b;
    logic [c_RGB_W-1:0]    w_bg;

    logic [c_IDX_W-1:0]    r_s1_idx_q,   w_s1_idx_d;
    logic                  r_s1_hit_q,   w_s1_hit_d;
    logic [c_RGB_W-1:0]    r_s1_bg_q,    w_s1_bg_d;
    logic                  r_s1_valid_q, w_s1_valid_d;

    logic [c_RGB_W-1:0]    r_rgb_q,       w_rgb_d;
    logic                  r_valid_out_q, w_valid_out_d;

    logic                  w_unused;
    assign w_unused = ^{DrawY, DrawX[2:0]};

    always_comb begin
        for (int i = 0; i < NUM_LAYERS; i++) begin
            case (default_color(i))
                PAL_WHITE: w_pal_rst[i] = {c_RGB_W{1'b1}};
                PAL_RED:   w_pal_rst[i] = {{COLOR_W{1'b1}}, {(2*COLOR_W){1'b0}}};
                PAL_GREEN: w_pal_rst[i] = {{COLOR_W{1'b0}}, {COLOR_W{1'b1}}, {COLOR_W{1'b0}}};
                default:   w_pal_rst[i] = '0;
            endcase
        end
    end

    // Writes land one cycle late so a pixel entering alongside a write still
    // resolves against the old entry when it reaches stage 2.
    assign w_wr_pend_d = pal_we && ({1'b0, pal_idx} < 5'(NUM_LAYERS));
    assign w_wr_idx_d  = pal_idx;
    assign w_wr_rgb_d  = pal_rgb;

    always_comb begin
        for (int i = 0; i < NUM_LAYERS; i++) begin
            w_pal_d[i] = r_pal_q[i];
            if (r_wr_pend_q && (r_wr_idx_q == 4'(i))) begin
                w_pal_d[i] = r_wr_rgb_q;
            end
        end
    end

    always_comb begin
        w_frame_cnt_d   = r_frame_cnt_q;
        w_blink_phase_d = r_blink_phase_q;
        if (frame_start) begin
            if (r_frame_cnt_q == c_CNT_LAST) begin
                w_frame_cnt_d   = '0;
                w_blink_phase_d = ~r_blink_phase_q;
            end else begin
                w_frame_cnt_d = r_frame_cnt_q + 8'd1;
            end
        end
    end

    assign w_eff = is_layer & ~(blink_en & {NUM_LAYERS{r_blink_phase_q}});

    layer_prio_enc #(
        .NUM_LAYERS (NUM_LAYERS),
        .IDX_W      (c_IDX_W)
    ) u_prio_enc (
        .i_vec (w_eff),
        .o_idx (w_win_idx),
        .o_hit (w_hit)
    );

    // Background gradient is defined at 8 bits and left-aligned to COLOR_W.
    assign w_bg_b8 = 8'h7F - {1'b0, DrawX[9:3]};
    assign w_bg_r  = COLOR_W'(8'h3F) << (COLOR_W - 8);
    assign w_bg_b  = COLOR_W'(w_bg_b8) << (COLOR_W - 8);
    assign w_bg    = {w_bg_r, {COLOR_W{1'b0}}, w_bg_b};

    always_comb begin
        w_s1_idx_d    = w_win_idx;
        w_s1_hit_d    = w_hit;
        w_s1_bg_d     = w_bg;
        w_s1_valid_d  = pix_valid;
        w_rgb_d       = r_s1_hit_q ? r_pal_q[r_s1_idx_q] : r_s1_bg_q;
        w_valid_out_d = r_s1_valid_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                r_pal_q[i] <= w_pal_rst[i];
            end
            r_wr_pend_q     <= 1'b0;
            r_wr_idx_q      <= '0;
            r_wr_rgb_q      <= '0;
            r_frame_cnt_q   <= '0;
            r_blink_phase_q <= 1'b0;
            r_s1_idx_q      <= '0;
            r_s1_hit_q      <= 1'b0;
            r_s1_bg_q       <= '0;
            r_s1_valid_q    <= 1'b0;
            r_rgb_q         <= '0;
            r_valid_out_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                r_pal_q[i] <= w_pal_d[i];
            end
            r_wr_pend_q     <= w_wr_pend_d;
            r_wr_idx_q      <= w_wr_idx_d;
            r_wr_rgb_q      <= w_wr_rgb_d;
            r_frame_cnt_q   <= w_frame_cnt_d;
            r_blink_phase_q <= w_blink_phase_d;
            r_s1_idx_q      <= w_s1_idx_d;
            r_s1_hit_q      <= w_s1_hit_d;
            r_s1_bg_q       <= w_s1_bg_d;
            r_s1_valid_q    <= w_s1_valid_d;
            r_rgb_q         <= w_rgb_d;
            r_valid_out_q   <= w_valid_out_d;
        end
    end

    assign VGA_R         = r_rgb_q[c_RGB_W-1:2*COLOR_W];
    assign VGA_G         = r_rgb_q[2*COLOR_W-1:COLOR_W];
    assign VGA_B         = r_rgb_q[COLOR_W-1:0];
    assign pix_valid_out = r_valid_out_q;

endmodule
`default_nettype wire

// File: tb/tb_layered_color_mapper.sv
`default_nettype none
// ============================================================================
// Module      : tb_layered_color_mapper
// Description : Directed self-checking bench for layered_color_mapper using a
//               4-layer/8-bit/2-frame instance and an 8-layer/10-bit instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_layered_color_mapper;

    logic        Clk;
    logic        Reset;
    logic        frame_start;
    logic        pix_valid;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;

    logic [3:0]  is_layer_a, blink_en_a, pal_idx_a;
    logic        pal_we_a;
    logic [23:0] pal_rgb_a;
    logic [7:0]  a_r, a_g, a_b;
    logic        a_pvo;

    logic [7:0]  is_layer_b, blink_en_b;
    logic [3:0]  pal_idx_b;
    logic        pal_we_b;
    logic [29:0] pal_rgb_b;
    logic [9:0]  b_r, b_g, b_b;
    logic        b_pvo;

    int n_checks = 0;
    int n_fail   = 0;

    layered_color_mapper #(
        .NUM_LAYERS(4), .COLOR_W(8), .BLINK_FRAMES(2)
    ) dut_a (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .pix_valid(pix_valid),
        .DrawX(DrawX), .DrawY(DrawY), .is_layer(is_layer_a), .blink_en(blink_en_a),
        .pal_we(pal_we_a), .pal_idx(pal_idx_a), .pal_rgb(pal_rgb_a),
        .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b), .pix_valid_out(a_pvo)
    );

    layered_color_mapper #(
        .NUM_LAYERS(8), .COLOR_W(10), .BLINK_FRAMES(30)
    ) dut_b (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .pix_valid(pix_valid),
        .DrawX(DrawX), .DrawY(DrawY), .is_layer(is_layer_b), .blink_en(blink_en_b),
        .pal_we(pal_we_b), .pal_idx(pal_idx_b), .pal_rgb(pal_rgb_b),
        .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b), .pix_valid_out(b_pvo)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [23:0] rgb, input logic pvo);
        chk({tag, "_rgb"}, {8'h00, a_r, a_g, a_b}, {8'h00, rgb});
        chk({tag, "_pvo"}, {31'd0, a_pvo}, {31'd0, pvo});
    endtask

    task automatic pulse();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; frame_start = 1'b0; pix_valid = 1'b0;
        DrawX = '0; DrawY = '0;
        is_layer_a = '0; blink_en_a = '0; pal_we_a = 1'b0; pal_idx_a = '0; pal_rgb_a = '0;
        is_layer_b = '0; blink_en_b = '0; pal_we_b = 1'b0; pal_idx_b = '0; pal_rgb_b = '0;
        tick(); tick();
        chk_a("reset", 24'h000000, 1'b0);
        chk("reset_b_rgb", {2'b00, b_r, b_g, b_b}, 32'h0);
        chk("reset_b_pvo", {31'd0, b_pvo}, 32'd0);
        Reset = 1'b0;

        // Lower index wins; default layer 2 is red, layer 7 of the wide instance is black.
        is_layer_a = 4'b1100; is_layer_b = 8'h80; pix_valid = 1'b1;
        tick(); tick();
        chk_a("prio_red", 24'hFF0000, 1'b1);
        chk("b_layer7_black", {2'b00, b_r, b_g, b_b}, 32'h0);
        chk("b_layer7_pvo", {31'd0, b_pvo}, 32'd1);

        // Background gradient; DrawY has no effect.
        is_layer_a = '0; is_layer_b = '0; DrawX = 10'd80; DrawY = 10'd477;
        tick(); tick();
        chk_a("bg_x80", 24'h3F0075, 1'b1);
        chk("b_bg_x80", {2'b00, b_r, b_g, b_b}, {2'b00, 10'h0FC, 10'h000, 10'h1D4});

        is_layer_b = 8'h81; DrawX = 10'd1023;
        tick(); tick();
        chk_a("bg_xmax", 24'h3F0000, 1'b1);
        chk("b_white10", {2'b00, b_r, b_g, b_b}, 32'h3FFF_FFFF);

        // Exact two-cycle latency for colour and valid.
        is_layer_a = 4'b0001; pix_valid = 1'b0;
        tick();
        chk_a("lat_1cyc", 24'h3F0000, 1'b1);
        tick();
        chk_a("lat_2cyc", 24'hFFFFFF, 1'b0);

        // Write coinciding with a lookup of the same entry.
        pix_valid = 1'b1; is_layer_a = 4'b0100;
        pal_we_a = 1'b1; pal_idx_a = 4'd2; pal_rgb_a = 24'h0000FF;
        tick();
        pal_we_a = 1'b0;
        tick();
        chk_a("wr_same_cyc", 24'hFF0000, 1'b1);
        tick();
        chk_a("wr_next_cyc", 24'h0000FF, 1'b1);

        // Out-of-range indices must not alias onto real entries.
        pal_we_a = 1'b1; pal_idx_a = 4'd9; pal_rgb_a = 24'hABCDEF;
        tick();
        pal_idx_a = 4'd4;
        tick();
        pal_we_a = 1'b0;
        is_layer_a = 4'b0001; tick();
        is_layer_a = 4'b0010; tick();
        chk_a("pal_e0", 24'hFFFFFF, 1'b1);
        is_layer_a = 4'b0100; tick();
        chk_a("pal_e1", 24'hFFFFFF, 1'b1);
        is_layer_a = 4'b1000; tick();
        chk_a("pal_e2", 24'h0000FF, 1'b1);
        tick();
        chk_a("pal_e3", 24'h00FF00, 1'b1);

        // Blink on layer 0 with a 2-frame half-period.
        blink_en_a = 4'b0001; is_layer_a = 4'b0011;
        tick(); tick();
        chk_a("blink_l0", 24'hFFFFFF, 1'b1);
        pulse(); pulse();
        tick(); tick();
        chk_a("blink_fall", 24'hFFFFFF, 1'b1);
        pal_we_a = 1'b1; pal_idx_a = 4'd1; pal_rgb_a = 24'h123456;
        tick();
        pal_we_a = 1'b0;
        tick(); tick();
        chk_a("blink_l1_new", 24'h123456, 1'b1);
        pulse();
        tick(); tick();
        chk_a("blink_cnt1", 24'h123456, 1'b1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        chk_a("blink_edge_old", 24'h123456, 1'b1);
        tick();
        chk_a("blink_edge_new", 24'hFFFFFF, 1'b1);
        pulse(); pulse();
        tick(); tick();
        chk_a("blink_again", 24'h123456, 1'b1);

        // Reset mid-stream with a simultaneous write and frame pulse.
        is_layer_a = 4'b0010;
        tick(); tick();
        chk_a("pre_rst", 24'h123456, 1'b1);
        Reset = 1'b1; pal_we_a = 1'b1; pal_idx_a = 4'd3; pal_rgb_a = 24'h123456; frame_start = 1'b1;
        tick();
        Reset = 1'b0; pal_we_a = 1'b0; frame_start = 1'b0; is_layer_a = 4'b0100;
        chk_a("rst_mid0", 24'h000000, 1'b0);
        tick();
        chk_a("rst_mid1", 24'h000000, 1'b0);
        is_layer_a = 4'b0001; tick();
        chk_a("rst_pal2", 24'hFF0000, 1'b1);
        is_layer_a = 4'b1000; tick();
        chk_a("rst_phase", 24'hFFFFFF, 1'b1);
        tick();
        chk_a("rst_pal3", 24'h00FF00, 1'b1);

        // Frame counter restarts from zero after reset.
        is_layer_a = 4'b0001;
        pulse();
        tick(); tick();
        chk_a("rst_cnt", 24'hFFFFFF, 1'b1);
        pulse();
        tick(); tick();
        chk_a("rst_cnt_wrap", 24'h3F0000, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
